regfile_param: RTL and testbench
================================

# regfile_param

Parametrised successor of the single-cycle CPU register file: configurable width and depth, two combinational read ports, one synchronous write port with a registered completion pulse. A sequential clear engine zeroes storage one entry per cycle after reset or a soft-clear request, so the array stays inferable as RAM. Optional hard-wired zero register and write-to-read bypass. Sits between decode (rs/rt/rd) and writeback in the CPU datapath.

## Interface
- DATA_W, 32, data width in bits
- ADDR_W, 5, register address width; NREGS = 2**ADDR_W entries
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read port
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- clr  in  1  soft clear request, sampled when not busy
- rs  in  ADDR_W  read port A address
- rt  in  ADDR_W  read port B address
- rd  in  ADDR_W  write address
- input_data  in  DATA_W  write data
- write  in  1  write enable
- rs_data  out  DATA_W  read port A data
- rt_data  out  DATA_W  read port B data
- write_finish  out  1  one-cycle pulse, cycle after an accepted write
- busy  out  1  clear engine active; writes ignored

## Operation
- States: CLEAR, READY. Counter clr_idx, ADDR_W bits.
- rst low at an edge: state<=CLEAR, clr_idx<=0, write_finish<=0. Storage untouched that edge. Held low: stays there.
- CLEAR, rst high: regarray[clr_idx]<=0, clr_idx<=clr_idx+1; at clr_idx==NREGS-1 state<=READY, clr_idx wraps to 0.
- READY, clr=1: state<=CLEAR, clr_idx<=0; a simultaneous write is dropped, write_finish<=0.
- READY, clr=0, write=1: accepted; regarray[rd]<=input_data (skipped if ZERO_REG and rd==0), write_finish<=1. rd==0 writes still pulse write_finish.
- Otherwise write_finish<=0. write/clr during CLEAR: ignored, no pulse.
- busy = (state==CLEAR), combinational from state.
- Reads: busy -> 0. ZERO_REG and address 0 -> 0. BYPASS and accepted write this cycle and rd==address -> input_data. Else regarray[address]. rs and rt independent; both may hit bypass.
- No width conversion; all data DATA_W, no sign handling.

## Timing
- Reset values: write_finish=0, busy=1, rs_data=rt_data=0.
- Clear takes exactly NREGS rising edges with rst high; busy falls after edge NREGS (32 for default).
- Read latency 0 (combinational). Write visible from storage after next edge; same cycle via bypass when BYPASS=1.
- write_finish high exactly one cycle, the cycle after acceptance; back-to-back writes give continuous high.
- rst low mid-clear: restarts from entry 0 on release. rst has priority over clr, clr over write.

## Structure
- Package regfile_pkg: state enum (CLEAR, READY), default DATA_W/ADDR_W constants.
- Sub-module regfile_clear_ctrl: state register, clr_idx counter, busy; outputs clear-write enable and index. Top holds array, write mux, read/bypass logic, write_finish.

## Test plan
- Release rst after 3 low cycles -> busy high 32 cycles, low on cycle 33; all 32 entries read 0.
- Write 0xDEADBEEF to r5, next cycle rs=5 -> rs_data=0xDEADBEEF; write_finish high exactly one cycle.
- Same cycle write r7=0x12345678 with rs=rt=7 -> both ports 0x12345678 (BYPASS=1); BYPASS=0 -> old value 0.
- Write 0xFFFFFFFF to r0 -> write_finish pulses, rs=0 reads 0 (ZERO_REG=1).
- Fill r1..r31, assert clr with write to r3 -> no pulse, busy 32 cycles, all reads 0; rst low at clear cycle 10 -> restart, full 32 more cycles.
- DATA_W=16, ADDR_W=3: clear takes 8 cycles; write 0xA5A5 to r7 reads back 0xA5A5.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the parametrised register file.
// State encoding for the clear engine plus default geometry.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Clear engine: walks every entry once after reset or a soft clear, one per cycle.
// Latency NREGS edges; no backpressure, busy simply gates the write port upstream.
module regfile_clear_ctrl
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  output logic              busy_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_idx_o
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // The counter wraps naturally to 0 on the last entry, ready for the next clear.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      CLEAR: begin
        idx_d = idx_q + ADDR_W'(1);
        if (idx_q == '1) state_d = READY;
      end
      READY: begin
        if (clr_i) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    busy_o    = (state_q == CLEAR);
    clr_we_o  = (state_q == CLEAR) && rst_i;
    clr_idx_o = idx_q;
  end

endmodule

// File: rtl/regfile_param.sv
// Register file: two combinational read ports, one write port, optional zero reg and bypass.
// Reads 0 cycles, write visible next edge (same cycle with bypass); writes dropped while busy.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] input_data,
  input  logic              write,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              write_finish,
  output logic              busy
);

  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regarray [NREGS];
  logic              busy_w;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_idx;
  logic              wr_accept;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic              write_finish_q;

  regfile_clear_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_clear_ctrl (
    .clk_i     (clk),
    .rst_i     (rst),
    .clr_i     (clr),
    .busy_o    (busy_w),
    .clr_we_o  (clr_we),
    .clr_idx_o (clr_idx)
  );

  assign wr_accept = rst && !busy_w && !clr && write;

  // Clear and normal writes share one port so the array maps onto a single-write RAM.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = rd;
    mem_wd = input_data;
    if (clr_we) begin
      mem_we = 1'b1;
      mem_wa = clr_idx;
      mem_wd = '0;
    end else if (wr_accept && !((ZERO_REG != 0) && (rd == '0))) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) regarray[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clk) begin
    if (!rst) write_finish_q <= 1'b0;
    else      write_finish_q <= wr_accept;
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    val = regarray[addr];
    if (busy_w)                                         val = '0;
    else if ((ZERO_REG != 0) && (addr == '0))           val = '0;
    else if ((BYPASS != 0) && wr_accept && (rd == addr)) val = input_data;
    return val;
  endfunction

  always_comb begin
    rs_data = read_port(rs);
    rt_data = read_port(rt);
  end

  assign write_finish = write_finish_q;
  assign busy         = busy_w;

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: default, no-bypass and 16x8 instances.
module tb_regfile_param;

  logic        clk = 1'b0;
  logic        rst, clr, write;
  logic [4:0]  rs, rt, rd;
  logic [31:0] input_data;
  logic [31:0] rs_data, rt_data, nb_rs_data, nb_rt_data;
  logic        write_finish, busy, nb_fin, nb_busy;

  logic        s_rst, s_clr, s_write;
  logic [2:0]  s_rs, s_rt, s_rd;
  logic [15:0] s_din, s_rs_data, s_rt_data;
  logic        s_fin, s_busy;

  always #5 clk = ~clk;

  regfile_param u_dut (
    .clk(clk), .rst(rst), .clr(clr), .rs(rs), .rt(rt), .rd(rd),
    .input_data(input_data), .write(write), .rs_data(rs_data), .rt_data(rt_data),
    .write_finish(write_finish), .busy(busy)
  );

  regfile_param #(.BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .clr(clr), .rs(rs), .rt(rt), .rd(rd),
    .input_data(input_data), .write(write), .rs_data(nb_rs_data), .rt_data(nb_rt_data),
    .write_finish(nb_fin), .busy(nb_busy)
  );

  regfile_param #(.DATA_W(16), .ADDR_W(3)) u_small (
    .clk(clk), .rst(s_rst), .clr(s_clr), .rs(s_rs), .rt(s_rt), .rd(s_rd),
    .input_data(s_din), .write(s_write), .rs_data(s_rs_data), .rt_data(s_rt_data),
    .write_finish(s_fin), .busy(s_busy)
  );

  typedef struct {
    logic        wr;
    logic [4:0]  a_rd;
    logic [31:0] din;
    logic [4:0]  a_rs;
    logic [4:0]  a_rt;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic [31:0] e_nb_rs;
  } vec_t;

  vec_t        vecs [7];
  logic [31:0] mdl [32];
  logic        fin_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One READY-state cycle: drive, compare at negedge, push the expected completion pulse.
  task automatic step(input logic w, input logic [4:0] a_rd, input logic [31:0] d,
                      input logic [4:0] a_rs, input logic [4:0] a_rt,
                      input logic [31:0] e_rs, input logic [31:0] e_rt,
                      input logic [31:0] e_nb_rs, input string nm);
    logic e;
    write = w; rd = a_rd; input_data = d; rs = a_rs; rt = a_rt; clr = 1'b0;
    @(negedge clk);
    if (fin_q.size() > 0) begin
      e = fin_q.pop_front();
      check({nm, "_fin"}, {31'd0, write_finish}, {31'd0, e});
      check({nm, "_fin_nb"}, {31'd0, nb_fin}, {31'd0, e});
    end
    check({nm, "_rs"}, rs_data, e_rs);
    check({nm, "_rt"}, rt_data, e_rt);
    check({nm, "_nb_rs"}, nb_rs_data, e_nb_rs);
    fin_q.push_back(w);
    if (w && a_rd != 5'd0) mdl[a_rd] = d;
    tick();
  endtask

  task automatic wait_clear(input string nm, input int exp);
    int n = 0;
    while (busy === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check(nm, n, exp);
  endtask

  task automatic readback_all(input string nm);
    for (int i = 0; i < 32; i++)
      step(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), mdl[i], mdl[31 - i], mdl[i], nm);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        32'h0};
    vecs[1] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7, 32'h12345678, 32'h12345678, 32'h0};
    vecs[3] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd7, 32'h0,        32'h12345678, 32'h0};
    vecs[4] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd5, 32'h0,        32'hDEADBEEF, 32'h0};
    vecs[5] = '{1'b1, 5'd5, 32'h00000001, 5'd5, 5'd7, 32'h00000001, 32'h12345678, 32'hDEADBEEF};
    vecs[6] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd31, 32'h00000001, 32'h0,       32'h00000001};

    rst = 1'b0; clr = 1'b0; write = 1'b0; rs = '0; rt = '0; rd = '0; input_data = '0;
    s_rst = 1'b0; s_clr = 1'b0; s_write = 1'b0; s_rs = '0; s_rt = '0; s_rd = '0; s_din = '0;

    repeat (3) tick();
    rs = 5'd4;
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_fin", {31'd0, write_finish}, 32'd0);
    check("rst_rs", rs_data, 32'd0);
    check("rst_rt", rt_data, 32'd0);
    tick();
    rst = 1'b1;
    wait_clear("init_clear_cycles", 32);
    check("init_nb_busy", {31'd0, nb_busy}, 32'd0);
    readback_all("init_zero");

    for (int i = 0; i < 7; i++)
      step(vecs[i].wr, vecs[i].a_rd, vecs[i].din, vecs[i].a_rs, vecs[i].a_rt,
           vecs[i].e_rs, vecs[i].e_rt, vecs[i].e_nb_rs, $sformatf("vec%0d", i));

    for (int i = 1; i < 32; i++)
      step(1'b1, 5'(i), 32'h01010101 * i, 5'(i), 5'(i - 1), 32'h01010101 * i,
           mdl[i - 1], mdl[i], "fill");
    readback_all("filled");

    // Soft clear with a simultaneous write: the write must be dropped and not pulse.
    write = 1'b1; rd = 5'd3; input_data = 32'hCAFEF00D; rs = 5'd3; rt = 5'd3; clr = 1'b1;
    @(negedge clk);
    void'(fin_q.pop_front());
    check("clr_cyc_busy", {31'd0, busy}, 32'd0);
    check("clr_cyc_rs", rs_data, mdl[3]);
    tick();
    clr = 1'b0; write = 1'b0;
    fin_q.delete();
    @(negedge clk);
    check("clr_fin", {31'd0, write_finish}, 32'd0);
    check("clr_busy", {31'd0, busy}, 32'd1);
    wait_clear("clr_cycles", 32);
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    readback_all("cleared");

    step(1'b1, 5'd9, 32'h99999999, 5'd9, 5'd0, 32'h99999999, 32'h0, 32'h0, "pre_restart");
    clr = 1'b1; write = 1'b0;
    @(negedge clk);
    check("restart_fin", {31'd0, write_finish}, 32'd1);
    tick();
    clr = 1'b0;
    fin_q.delete();
    repeat (10) tick();
    rst = 1'b0;
    @(negedge clk);
    check("restart_busy_in_rst", {31'd0, busy}, 32'd1);
    tick();
    rst = 1'b1;
    wait_clear("restart_cycles", 32);
    mdl[9] = 32'd0;
    step(1'b0, 5'd0, 32'd0, 5'd9, 5'd1, 32'h0, 32'h0, 32'h0, "restart_r9");

    s_rst = 1'b1;
    begin
      int n = 0;
      while (s_busy === 1'b1 && n < 200) begin
        tick();
        n++;
      end
      check("small_clear_cycles", n, 8);
    end
    s_write = 1'b1; s_rd = 3'd7; s_din = 16'hA5A5; s_rs = 3'd7; s_rt = 3'd2;
    @(negedge clk);
    check("small_bypass_rs", {16'd0, s_rs_data}, 32'h0000A5A5);
    check("small_rt", {16'd0, s_rt_data}, 32'h0);
    tick();
    s_write = 1'b0;
    @(negedge clk);
    check("small_fin", {31'd0, s_fin}, 32'd1);
    check("small_read", {16'd0, s_rs_data}, 32'h0000A5A5);
    tick();
    @(negedge clk);
    check("small_fin_off", {31'd0, s_fin}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
